// File: rtl/fetch_queue_unit.sv
// Instruction-fetch front end: PC-sequential requests to a variable-latency memory,
// a prefetch queue of {pc, instr} pairs, branch redirect flushing and halt-opcode stop.
module fetch_queue_unit #(
   parameter int unsigned       ADDR_W   = 16,
   parameter int unsigned       INSTR_W  = 16,
   parameter int unsigned       DEPTH    = 4,
   parameter logic [ADDR_W-1:0] RESET_PC = '0,
   parameter int unsigned       OPC_W    = 4,
   parameter logic [OPC_W-1:0]  HALT_OPC = 4'hF
) (
   input  logic                         clk,
   input  logic                         rst,
   output logic                         imem_req,
   output logic [ADDR_W-1:0]            imem_addr,
   input  logic                         imem_ready,
   input  logic                         imem_rvalid,
   input  logic [INSTR_W-1:0]           imem_rdata,
   output logic                         instr_valid,
   output logic [INSTR_W-1:0]           instr,
   output logic [ADDR_W-1:0]            instr_pc,
   input  logic                         instr_ready,
   input  logic                         redirect,
   input  logic [ADDR_W-1:0]            redirect_pc,
   output logic                         halted,
   output logic [ADDR_W-1:0]            pc,
   output logic [$clog2(DEPTH+1)-1:0]   q_count
);

   localparam int unsigned       CNT_W = $clog2(DEPTH + 1);
   localparam int unsigned       PTR_W = $clog2(DEPTH);
   localparam logic [ADDR_W-1:0] STEP  = ADDR_W'(INSTR_W / 8);
   localparam logic [ADDR_W-1:0] EVEN  = ~ADDR_W'(1);

   typedef enum logic [1:0] {StFetch, StWait, StDrop, StHalt} state_e;

   state_e              state_q, state_d;
   logic [ADDR_W-1:0]   pc_q, pc_d;
   logic [ADDR_W-1:0]   fly_q, fly_d;
   logic                halted_q, halted_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic [PTR_W-1:0]    rd_q, rd_d, wr_q, wr_d;
   logic [ADDR_W-1:0]   qpc_q  [DEPTH];
   logic [INSTR_W-1:0]  qins_q [DEPTH];
   logic                accept, enq, deq, is_halt;

   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
      return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
   endfunction

   // FETCH never has a request in flight, so q_count alone reserves the slot.
   assign imem_req    = rst && (state_q == StFetch) && !redirect && (cnt_q < CNT_W'(DEPTH));
   assign accept      = imem_req && imem_ready;
   assign is_halt     = (imem_rdata[INSTR_W-1 -: OPC_W] == HALT_OPC);
   assign enq         = (state_q == StWait) && imem_rvalid && !redirect;
   assign deq         = instr_valid && instr_ready && !redirect;

   assign imem_addr   = pc_q & EVEN;
   assign instr_valid = (cnt_q != '0);
   assign instr       = qins_q[rd_q];
   assign instr_pc    = qpc_q[rd_q];
   assign halted      = halted_q;
   assign pc          = pc_q;
   assign q_count     = cnt_q;

   always_comb begin
      state_d  = state_q;
      pc_d     = pc_q;
      fly_d    = fly_q;
      halted_d = halted_q;
      cnt_d    = cnt_q;
      rd_d     = rd_q;
      wr_d     = wr_q;
      if (redirect) begin
         pc_d     = redirect_pc & EVEN;
         halted_d = 1'b0;
         cnt_d    = '0;
         rd_d     = '0;
         wr_d     = '0;
         // An outstanding response must still be absorbed unless it lands right now.
         unique case (state_q)
            StWait, StDrop: state_d = imem_rvalid ? StFetch : StDrop;
            default:        state_d = StFetch;
         endcase
      end else begin
         if (enq) wr_d = ptr_inc(wr_q);
         if (deq) rd_d = ptr_inc(rd_q);
         unique case ({enq, deq})
            2'b10:   cnt_d = cnt_q + 1'b1;
            2'b01:   cnt_d = cnt_q - 1'b1;
            default: cnt_d = cnt_q;
         endcase
         unique case (state_q)
            StFetch: begin
               if (accept) begin
                  fly_d   = pc_q;
                  pc_d    = pc_q + STEP;
                  state_d = StWait;
               end
            end
            StWait: begin
               if (imem_rvalid) begin
                  state_d  = is_halt ? StHalt : StFetch;
                  halted_d = is_halt;
               end
            end
            StDrop: begin
               if (imem_rvalid) state_d = StFetch;
            end
            default: state_d = state_q;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q  <= StFetch;
         pc_q     <= RESET_PC & EVEN;
         fly_q    <= '0;
         halted_q <= 1'b0;
         cnt_q    <= '0;
         rd_q     <= '0;
         wr_q     <= '0;
      end else begin
         state_q  <= state_d;
         pc_q     <= pc_d;
         fly_q    <= fly_d;
         halted_q <= halted_d;
         cnt_q    <= cnt_d;
         rd_q     <= rd_d;
         wr_q     <= wr_d;
      end
   end

   always_ff @(posedge clk) begin
      if (enq) begin
         qpc_q[wr_q]  <= fly_q;
         qins_q[wr_q] <= imem_rdata;
      end
   end

endmodule

// File: tb/tb_fetch_queue_unit.sv
// Directed bench for fetch_queue_unit: sequential fetch, backpressure, redirect,
// halt, PC wrap and mid-transaction reset, against a latency-configurable memory model.
module tb_fetch_queue_unit;

   localparam int unsigned AW = 16;
   localparam int unsigned IW = 16;

   logic          clk = 1'b0;
   logic          rst = 1'b0;
   logic          imem_req, imem_ready, imem_rvalid;
   logic [AW-1:0] imem_addr;
   logic [IW-1:0] imem_rdata;
   logic          instr_valid, instr_ready, redirect, halted;
   logic [IW-1:0] instr;
   logic [AW-1:0] instr_pc, redirect_pc, pc;
   logic [2:0]    q_count;

   logic          w_req, w_valid, w_halted;
   logic          w_ready    = 1'b1;
   logic          w_rvalid   = 1'b0;
   logic          w_iready   = 1'b1;
   logic          w_redirect = 1'b0;
   logic [AW-1:0] w_addr, w_ipc, w_pc;
   logic [AW-1:0] w_rpc      = '0;
   logic [IW-1:0] w_rdata    = 16'h0001;
   logic [IW-1:0] w_instr;
   logic [2:0]    w_cnt;

   int checks = 0;
   int errors = 0;
   int cyc    = 0;
   int lat    = 1;
   logic halt6 = 1'b0;
   int mcnt   = 0;
   logic [AW-1:0] maddr = '0;

   logic [AW-1:0] acc_q[$];
   int            acc_cyc[$];
   logic [AW-1:0] del_pc[$];
   logic [IW-1:0] del_ins[$];
   logic [AW-1:0] wacc_q[$];

   always #5 clk = ~clk;

   fetch_queue_unit dut (
      .clk(clk), .rst(rst), .imem_req(imem_req), .imem_addr(imem_addr),
      .imem_ready(imem_ready), .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
      .instr_valid(instr_valid), .instr(instr), .instr_pc(instr_pc),
      .instr_ready(instr_ready), .redirect(redirect), .redirect_pc(redirect_pc),
      .halted(halted), .pc(pc), .q_count(q_count)
   );

   fetch_queue_unit #(.RESET_PC(16'hFFFE)) dut_w (
      .clk(clk), .rst(rst), .imem_req(w_req), .imem_addr(w_addr),
      .imem_ready(w_ready), .imem_rvalid(w_rvalid), .imem_rdata(w_rdata),
      .instr_valid(w_valid), .instr(w_instr), .instr_pc(w_ipc),
      .instr_ready(w_iready), .redirect(w_redirect), .redirect_pc(w_rpc),
      .halted(w_halted), .pc(w_pc), .q_count(w_cnt)
   );

   function automatic logic [IW-1:0] mem_data(input logic [AW-1:0] a);
      logic [IW-1:0] d;
      d = IW'((a >> 1) * 3);
      if (halt6 && a == 16'h0006) d = 16'hF000;
      return d;
   endfunction

   // Memory model: one response lat cycles after acceptance.
   always @(posedge clk) begin
      cyc <= cyc + 1;
      w_rvalid <= w_req && w_ready;
      if (imem_req && imem_ready) begin
         mcnt  <= lat;
         maddr <= imem_addr;
      end else if (mcnt > 0) begin
         mcnt <= mcnt - 1;
      end
   end
   assign imem_rvalid = (mcnt == 1);
   assign imem_rdata  = mem_data(maddr);

   always @(negedge clk) begin
      if (imem_req && imem_ready) begin
         acc_q.push_back(imem_addr);
         acc_cyc.push_back(cyc);
      end
      if (instr_valid && instr_ready) begin
         del_pc.push_back(instr_pc);
         del_ins.push_back(instr);
      end
      if (w_req && w_ready) wacc_q.push_back(w_addr);
   end

   task automatic step(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic clear_logs();
      acc_q.delete();
      acc_cyc.delete();
      del_pc.delete();
      del_ins.delete();
      wacc_q.delete();
   endtask

   task automatic do_reset(input int l, input logic ir);
      rst = 1'b0; imem_ready = 1'b1; instr_ready = ir; redirect = 1'b0;
      redirect_pc = '0; lat = l;
      step(2);
      rst = 1'b1;
      clear_logs();
   endtask

   task automatic test_reset();
      rst = 1'b0; imem_ready = 1'b1; instr_ready = 1'b1; redirect = 1'b0; redirect_pc = '0;
      step(2);
      @(negedge clk);
      checks++; if (q_count !== 3'd0) begin errors++; $display("FAIL reset_qcount got %0d want 0", q_count); end
      checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", instr_valid); end
      checks++; if (halted !== 1'b0) begin errors++; $display("FAIL reset_halted got %b want 0", halted); end
      checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL reset_req got %b want 0", imem_req); end
      checks++; if (pc !== 16'h0000) begin errors++; $display("FAIL reset_pc got %h want 0000", pc); end
   endtask

   task automatic test_sequential();
      logic [AW-1:0] ep [3];
      logic [IW-1:0] ei [3];
      ep = '{16'h0000, 16'h0002, 16'h0004};
      ei = '{16'd0, 16'd3, 16'd6};
      do_reset(1, 1'b1);
      step(10);
      for (int i = 0; i < 3; i++) begin
         checks++; if (del_pc[i] !== ep[i]) begin errors++; $display("FAIL seq_pc[%0d] got %h want %h", i, del_pc[i], ep[i]); end
         checks++; if (del_ins[i] !== ei[i]) begin errors++; $display("FAIL seq_instr[%0d] got %h want %h", i, del_ins[i], ei[i]); end
      end
      for (int i = 1; i < 4; i++) begin
         checks++; if (acc_cyc[i] - acc_cyc[i-1] !== 2) begin errors++; $display("FAIL seq_spacing[%0d] got %0d want 2", i, acc_cyc[i] - acc_cyc[i-1]); end
      end
   endtask

   task automatic test_backpressure();
      do_reset(1, 1'b0);
      step(12);
      @(negedge clk);
      checks++; if (acc_q.size() !== 4) begin errors++; $display("FAIL bp_accepts got %0d want 4", acc_q.size()); end
      checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL bp_req got %b want 0", imem_req); end
      checks++; if (q_count !== 3'd4) begin errors++; $display("FAIL bp_qcount got %0d want 4", q_count); end
      checks++; if (instr_pc !== 16'h0000) begin errors++; $display("FAIL bp_head got %h want 0000", instr_pc); end
      step(1);
      clear_logs();
      instr_ready = 1'b1;
      step(10);
      for (int i = 0; i < 4; i++) begin
         checks++; if (del_pc[i] !== AW'(2 * i)) begin errors++; $display("FAIL bp_drain[%0d] got %h want %h", i, del_pc[i], AW'(2 * i)); end
      end
      checks++; if (acc_q[0] !== 16'h0008) begin errors++; $display("FAIL bp_resume got %h want 0008", acc_q[0]); end
   endtask

   task automatic test_redirect();
      do_reset(3, 1'b1);
      step(1);
      clear_logs();
      redirect = 1'b1; redirect_pc = 16'h0101;
      @(negedge clk);
      checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL redir_req got %b want 0", imem_req); end
      step(1);
      redirect = 1'b0;
      @(negedge clk);
      checks++; if (q_count !== 3'd0) begin errors++; $display("FAIL redir_qcount got %0d want 0", q_count); end
      checks++; if (pc !== 16'h0100) begin errors++; $display("FAIL redir_pc got %h want 0100", pc); end
      checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL redir_drop_req got %b want 0", imem_req); end
      step(2);
      @(negedge clk);
      checks++; if (q_count !== 3'd0) begin errors++; $display("FAIL redir_discard got %0d want 0", q_count); end
      step(10);
      checks++; if (acc_q[0] !== 16'h0100) begin errors++; $display("FAIL redir_newreq got %h want 0100", acc_q[0]); end
      checks++; if (del_pc[0] !== 16'h0100) begin errors++; $display("FAIL redir_first_pc got %h want 0100", del_pc[0]); end
      checks++; if (del_ins[0] !== 16'h0180) begin errors++; $display("FAIL redir_first_instr got %h want 0180", del_ins[0]); end
   endtask

   task automatic test_halt();
      halt6 = 1'b1;
      do_reset(1, 1'b1);
      step(12);
      @(negedge clk);
      checks++; if (acc_q.size() !== 4) begin errors++; $display("FAIL halt_accepts got %0d want 4", acc_q.size()); end
      checks++; if (acc_q[3] !== 16'h0006) begin errors++; $display("FAIL halt_lastreq got %h want 0006", acc_q[3]); end
      checks++; if (halted !== 1'b1) begin errors++; $display("FAIL halt_flag got %b want 1", halted); end
      checks++; if (del_pc[3] !== 16'h0006) begin errors++; $display("FAIL halt_pc got %h want 0006", del_pc[3]); end
      checks++; if (del_ins[3] !== 16'hF000) begin errors++; $display("FAIL halt_instr got %h want f000", del_ins[3]); end
      step(1);
      clear_logs();
      redirect = 1'b1; redirect_pc = 16'h0020;
      step(1);
      redirect = 1'b0;
      @(negedge clk);
      checks++; if (halted !== 1'b0) begin errors++; $display("FAIL halt_clear got %b want 0", halted); end
      step(3);
      checks++; if (acc_q[0] !== 16'h0020) begin errors++; $display("FAIL halt_restart got %h want 0020", acc_q[0]); end
      halt6 = 1'b0;
   endtask

   task automatic test_wrap();
      do_reset(1, 1'b1);
      step(6);
      checks++; if (wacc_q[0] !== 16'hFFFE) begin errors++; $display("FAIL wrap_first got %h want fffe", wacc_q[0]); end
      checks++; if (wacc_q[1] !== 16'h0000) begin errors++; $display("FAIL wrap_second got %h want 0000", wacc_q[1]); end
      checks++; if (wacc_q[2] !== 16'h0002) begin errors++; $display("FAIL wrap_third got %h want 0002", wacc_q[2]); end
   endtask

   task automatic test_mid_reset();
      do_reset(3, 1'b0);
      step(9);
      @(negedge clk);
      checks++; if (q_count !== 3'd2) begin errors++; $display("FAIL mid_setup_qcount got %0d want 2", q_count); end
      step(1);
      rst = 1'b0; imem_ready = 1'b0;
      step(1);
      rst = 1'b1;
      @(negedge clk);
      checks++; if (q_count !== 3'd0) begin errors++; $display("FAIL mid_qcount got %0d want 0", q_count); end
      checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL mid_valid got %b want 0", instr_valid); end
      checks++; if (halted !== 1'b0) begin errors++; $display("FAIL mid_halted got %b want 0", halted); end
      checks++; if (imem_req !== 1'b1) begin errors++; $display("FAIL mid_req got %b want 1", imem_req); end
      step(3);
      @(negedge clk);
      checks++; if (q_count !== 3'd0) begin errors++; $display("FAIL mid_stale got %0d want 0", q_count); end
      step(1);
      clear_logs();
      imem_ready = 1'b1;
      step(3);
      checks++; if (acc_q[0] !== 16'h0000) begin errors++; $display("FAIL mid_firstreq got %h want 0000", acc_q[0]); end
   endtask

   initial begin
      test_reset();
      test_sequential();
      test_backpressure();
      test_redirect();
      test_halt();
      test_wrap();
      test_mid_reset();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
